stage_wb_mp: RTL

- Parametrised successor to the single-lane writeback stage.
- Registers NLANES parallel memory-stage results, with lane 0 the oldest in program order.
- Aligns, truncates and sign/zero-extends load data using the byte offset.
- Commits results to an internal NREGS x XLEN register file, with NRD bypassed read ports for decode.
- Keeps a 64-bit retired-instruction counter that software can load.

---
 rtl/stage_wb_mp_pkg.sv | 64 ++++++
 rtl/wb_regfile.sv | 62 ++++++
 rtl/stage_wb_mp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stage_wb_mp_pkg.sv
// Shared types and helpers for the multi-lane writeback stage.
//   wb_lane_t     : one registered lane, sized for the widest build (XLEN=64, RW=5).
//   MSZ_*         : memory access size encoding carried by loads.
//   WB_LANE_RESET : lane value after reset (a bubble with every field zero).
//   load_extend() : aligns, truncates and extends a raw load word.
package stage_wb_mp_pkg;

    localparam logic [1:0] MSZ_B = 2'd0;
    localparam logic [1:0] MSZ_H = 2'd1;
    localparam logic [1:0] MSZ_W = 2'd2;
    localparam logic [1:0] MSZ_D = 2'd3;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic        mem_r;
        logic [1:0]  mem_sz;
        logic        mem_sx;
        logic [2:0]  mem_off;
        logic        bubble;
    } wb_lane_t;

    localparam wb_lane_t WB_LANE_RESET = '{
        pc:      64'd0,
        res:     64'd0,
        rd:      5'd0,
        w_rd:    1'b0,
        mem_r:   1'b0,
        mem_sz:  2'd0,
        mem_sx:  1'b0,
        mem_off: 3'd0,
        bubble:  1'b1
    };

    // res must arrive zero-extended to 64 bits; the caller keeps the low
    // xlen bits of the result. Misaligned offsets are not trapped: the
    // selected bytes simply run off the top of the word.
    function automatic logic [63:0] load_extend(
        input logic [63:0] res,
        input logic [1:0]  sz,
        input logic        sx,
        input logic [2:0]  off,
        input int unsigned xlen
    );
        logic [2:0]  off_eff;
        logic [63:0] shifted;
        logic [63:0] ext;
        off_eff = (xlen == 32) ? {1'b0, off[1:0]} : off;
        shifted = res >> {off_eff, 3'b000};
        case (sz)
            MSZ_B:   ext = {{56{sx & shifted[7]}}, shifted[7:0]};
            MSZ_H:   ext = {{48{sx & shifted[15]}}, shifted[15:0]};
            MSZ_W: begin
                if (xlen == 64) ext = {{32{sx & shifted[31]}}, shifted[31:0]};
                else            ext = shifted;
            end
            default: ext = shifted;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Register file written by the writeback lanes, read by decode.
//   clk, rst          : clock, asynchronous active-low reset (clears all registers).
//   wr_en/addr/data   : one write port per lane; lane NLANES-1 is the youngest.
//   rd_addr/rd_data   : NRD combinational read ports, bypassed from the write ports.
module wb_regfile #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NLANES   = 2,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RW       = $clog2(NREGS),
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NLANES-1:0]              wr_en,
    input  logic [NLANES-1:0][RW-1:0]      wr_addr,
    input  logic [NLANES-1:0][XLEN-1:0]    wr_data,
    input  logic [NRD-1:0][RW-1:0]         rd_addr,
    output logic [NRD-1:0][XLEN-1:0]       rd_data
);

    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] regs_q [NREGS];

    // Lanes are applied oldest first so a younger lane overwrites an older
    // one that targets the same register.
    always_comb begin
        regs_d = regs_q;
        for (int l = 0; l < int'(NLANES); l++) begin
            if (wr_en[l] && !((ZERO_REG != 0) && (wr_addr[l] == '0))) begin
                regs_d[wr_addr[l]] = wr_data[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same oldest-to-youngest scan as the write side so the bypass returns
    // exactly what the register will hold after the edge.
    always_comb begin
        for (int i = 0; i < int'(NRD); i++) begin
            rd_data[i] = regs_q[rd_addr[i]];
            for (int l = 0; l < int'(NLANES); l++) begin
                if (wr_en[l] && (wr_addr[l] == rd_addr[i])) begin
                    rd_data[i] = wr_data[l];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[i] == '0)) begin
                rd_data[i] = '0;
            end
        end
    end

endmodule

// File: rtl/stage_wb_mp.sv
// Multi-lane writeback stage.
//   clk, rst         : clock, asynchronous active-low reset.
//   in_*             : memory-stage results per lane, lane 0 oldest.
//   out_*            : registered lanes; out_res carries the extended load value.
//   rd_addr/rd_data  : bypassed register file read ports for decode.
//   instret*         : 64-bit retired-instruction counter with software load.
module stage_wb_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NLANES   = 2,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RW       = $clog2(NREGS),
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NLANES-1:0][XLEN-1:0]    in_pc,
    input  logic [NLANES-1:0][XLEN-1:0]    in_res,
    input  logic [NLANES-1:0][RW-1:0]      in_rd,
    input  logic [NLANES-1:0]              in_w_rd,
    input  logic [NLANES-1:0]              in_mem_r,
    input  logic [NLANES-1:0][1:0]         in_mem_sz,
    input  logic [NLANES-1:0]              in_mem_sx,
    input  logic [NLANES-1:0][2:0]         in_mem_off,
    input  logic [NLANES-1:0]              in_bubble,
    output logic [NLANES-1:0][XLEN-1:0]    out_pc,
    output logic [NLANES-1:0][XLEN-1:0]    out_res,
    output logic [NLANES-1:0][RW-1:0]      out_rd,
    output logic [NLANES-1:0]              out_w_rd,
    output logic [NLANES-1:0]              out_bubble,
    input  logic [NRD-1:0][RW-1:0]         rd_addr,
    output logic [NRD-1:0][XLEN-1:0]       rd_data,
    output logic [63:0]                    instret,
    input  logic                           instret_we,
    input  logic [63:0]                    instret_wdata
);

    import stage_wb_mp_pkg::*;

    wb_lane_t    lane_d [NLANES];
    wb_lane_t    lane_q [NLANES];
    logic        started_d, started_q;
    logic [63:0] instret_d, instret_q;
    logic [2:0]  retire_cnt;
    logic [63:0] ext_res [NLANES];
    logic        unused_lane_bits;

    // Capture: the first edge after reset release still loads bubbles, and
    // the final write enable is resolved here so the register file and the
    // out_w_rd port see the same qualified value.
    always_comb begin
        started_d = 1'b1;
        for (int l = 0; l < int'(NLANES); l++) begin
            lane_d[l]                = '0;
            lane_d[l].pc[XLEN-1:0]   = in_pc[l];
            lane_d[l].res[XLEN-1:0]  = in_res[l];
            lane_d[l].rd[RW-1:0]     = in_rd[l];
            lane_d[l].mem_r          = in_mem_r[l];
            lane_d[l].mem_sz         = in_mem_sz[l];
            lane_d[l].mem_sx         = in_mem_sx[l];
            lane_d[l].mem_off        = in_mem_off[l];
            lane_d[l].bubble         = in_bubble[l] | ~started_q;
            lane_d[l].w_rd           = in_w_rd[l] & ~lane_d[l].bubble
                                       & !((ZERO_REG != 0) && (in_rd[l] == '0));
        end
    end

    // Retirement: every non-bubble lane counts, even one whose write was
    // dropped, and a software load still absorbs this cycle's retirements.
    always_comb begin
        retire_cnt = '0;
        for (int l = 0; l < int'(NLANES); l++) begin
            if (!lane_q[l].bubble) retire_cnt = retire_cnt + 3'd1;
        end
        instret_d = (instret_we ? instret_wdata : instret_q) + {61'd0, retire_cnt};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q <= 1'b0;
            instret_q <= '0;
            for (int l = 0; l < int'(NLANES); l++) begin
                lane_q[l] <= WB_LANE_RESET;
            end
        end else begin
            started_q <= started_d;
            instret_q <= instret_d;
            for (int l = 0; l < int'(NLANES); l++) begin
                lane_q[l] <= lane_d[l];
            end
        end
    end

    // Result formation from the stage registers.
    always_comb begin
        for (int l = 0; l < int'(NLANES); l++) begin
            ext_res[l]    = load_extend(lane_q[l].res, lane_q[l].mem_sz, lane_q[l].mem_sx,
                                        lane_q[l].mem_off, XLEN);
            out_pc[l]     = lane_q[l].pc[XLEN-1:0];
            out_res[l]    = lane_q[l].mem_r ? ext_res[l][XLEN-1:0] : lane_q[l].res[XLEN-1:0];
            out_rd[l]     = lane_q[l].rd[RW-1:0];
            out_w_rd[l]   = lane_q[l].w_rd;
            out_bubble[l] = lane_q[l].bubble;
        end
    end

    // The lane struct is sized for the widest build; upper bits stay zero
    // in narrower builds and are folded here so they are not left dangling.
    always_comb begin
        unused_lane_bits = 1'b0;
        for (int l = 0; l < int'(NLANES); l++) begin
            unused_lane_bits = unused_lane_bits ^ (^lane_q[l]);
        end
    end

    assign instret = instret_q;

    wb_regfile #(
        .XLEN     (XLEN),
        .NLANES   (NLANES),
        .NREGS    (NREGS),
        .RW       (RW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (out_w_rd),
        .wr_addr (out_rd),
        .wr_data (out_res),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
